// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32 fetch stage owning the PC and the IF/ID register, with stall, redirect, EBREAK halt and misaligned-target fault
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_instr,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_if_valid,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_pc4,
    output logic        o_halted,
    output logic        o_fetch_fault
);
    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
    state_t state, state_n;
    logic [31:0] pc, pc_n, instr_n, ipc_n, ipc4_n;
    logic valid_n;
    logic ebreak;
    assign ebreak = i_imem_instr == 32'h0010_0073;
    always_comb begin
        state_n = state;
        pc_n = pc;
        valid_n = o_if_valid;
        instr_n = o_if_instr;
        ipc_n = o_if_pc;
        ipc4_n = o_if_pc4;
        if (state != FAULT) begin
            if (i_redirect) begin
                pc_n = i_redirect_pc;
                valid_n = 1'b0;
                state_n = i_redirect_pc[1:0] != 2'b00 ? FAULT : RUN;
            end else if (!i_stall) begin
                if (state == HALT) begin
                    valid_n = 1'b0;
                end else begin
                    valid_n = 1'b1;
                    instr_n = i_imem_instr;
                    ipc_n = pc;
                    ipc4_n = pc + 32'd4;
                    pc_n = ebreak ? pc : pc + 32'd4;
                    state_n = ebreak ? HALT : RUN;
                end
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= RUN;
            pc <= RESET_PC;
            o_if_valid <= 1'b0;
            o_if_instr <= '0;
            o_if_pc <= '0;
            o_if_pc4 <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            o_if_valid <= valid_n;
            o_if_instr <= instr_n;
            o_if_pc <= ipc_n;
            o_if_pc4 <= ipc4_n;
        end
    end
    assign o_imem_addr = pc;
    assign o_halted = state == HALT;
    assign o_fetch_fault = state == FAULT;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed plan steps then random traffic against a transaction-level fetch model; second instance covers PC wrap
module tb_instruction_fetch;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    logic clk = 1'b0;
    logic rst = 1'b1, stall = 1'b0, redir = 1'b0;
    logic [31:0] rpc = '0;
    logic [31:0] addr, instr, if_instr, if_pc, if_pc4;
    logic if_valid, halted, fault;
    logic [31:0] rom [64];
    logic w_rst = 1'b1;
    logic [31:0] w_addr, w_instr, w_if_instr, w_if_pc, w_if_pc4;
    logic w_valid, w_halted, w_fault;
    int n_chk = 0, n_pass = 0;
    logic [31:0] m_pc = '0, m_i = '0, m_p = '0, m_p4 = '0;
    logic m_v = 1'b0, m_known = 1'b1;
    int m_mode = 0;

    always #5 clk = ~clk;
    assign instr = rom[addr[7:2]];
    assign w_instr = {w_addr[15:0], 16'h1234};

    instruction_fetch dut (
        .i_clk(clk), .i_rst(rst), .o_imem_addr(addr), .i_imem_instr(instr),
        .i_stall(stall), .i_redirect(redir), .i_redirect_pc(rpc),
        .o_if_valid(if_valid), .o_if_instr(if_instr), .o_if_pc(if_pc), .o_if_pc4(if_pc4),
        .o_halted(halted), .o_fetch_fault(fault)
    );
    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .i_clk(clk), .i_rst(w_rst), .o_imem_addr(w_addr), .i_imem_instr(w_instr),
        .i_stall(1'b0), .i_redirect(1'b0), .i_redirect_pc(32'h0),
        .o_if_valid(w_valid), .o_if_instr(w_if_instr), .o_if_pc(w_if_pc), .o_if_pc4(w_if_pc4),
        .o_halted(w_halted), .o_fetch_fault(w_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Model: 0 = running, 1 = halted on EBREAK, 2 = faulted
    task automatic model(input logic r, input logic s, input logic d, input logic [31:0] t);
        logic [31:0] w;
        if (r) begin
            m_pc = '0; m_v = 0; m_i = '0; m_p = '0; m_p4 = '0; m_mode = 0; m_known = 1;
        end else if (m_mode == 2) begin
        end else if (d) begin
            m_pc = t; m_v = 0; m_known = 0;
            m_mode = (t % 4 != 0) ? 2 : 0;
        end else if (s) begin
        end else if (m_mode == 1) begin
            m_v = 0; m_known = 0;
        end else begin
            w = rom[m_pc[7:2]];
            m_v = 1; m_i = w; m_p = m_pc; m_p4 = m_pc + 4;
            if (w == EBREAK) m_mode = 1;
            else m_pc = m_pc + 4;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
        rst = r; stall = s; redir = d; rpc = t;
        model(r, s, d, t);
        @(posedge clk);
        #1;
        check("imem_addr", addr, m_pc);
        check("if_valid", {31'b0, if_valid}, {31'b0, m_v});
        check("halted", {31'b0, halted}, {31'b0, m_mode == 1});
        check("fetch_fault", {31'b0, fault}, {31'b0, m_mode == 2});
        if (m_v || m_known) begin
            check("if_instr", if_instr, m_i);
            check("if_pc", if_pc, m_p);
            check("if_pc4", if_pc4, m_p4);
        end
    endtask

    initial begin
        logic [31:0] hold_i, hold_p;
        for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;
        // reset and linear fetch
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reset_instr", if_instr, 32'h0);
        step(0, 0, 0, 0);
        check("first_A", if_instr, 32'h1000_0000);
        step(0, 0, 0, 0);
        hold_i = if_instr; hold_p = if_pc;
        // stall holds B@4
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        check("stall_instr_frozen", if_instr, hold_i);
        check("stall_pc_frozen", if_pc, hold_p);
        check("stall_addr", addr, 32'h8);
        step(0, 0, 0, 0);
        check("after_stall_C", if_pc, 32'h8);
        step(0, 0, 0, 0);
        // redirect during stall
        step(0, 1, 1, 32'h10);
        check("redir_bubble_addr", addr, 32'h10);
        step(0, 0, 0, 0);
        check("redir_target", if_instr, 32'h1000_0004);
        // EBREAK halt, stall while halted, wrong-path recovery
        rom[2] = EBREAK;
        step(0, 0, 1, 32'h0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("ebreak_in_ifid", if_instr, EBREAK);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("halt_pc_stuck", addr, 32'h8);
        step(0, 0, 1, 32'h0);
        step(0, 0, 0, 0);
        check("resume_A", if_pc, 32'h0);
        // misaligned redirect, sticky fault, reset recovery
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h6);
        check("fault_pc_kept", addr, 32'h6);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h20);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("after_fault_reset", if_pc, 32'h0);
        // random traffic
        for (int i = 0; i < 64; i++) rom[i] = ($urandom_range(0, 15) == 0) ? EBREAK : $urandom;
        for (int i = 0; i < 400; i++) begin
            logic r, s, d;
            logic [31:0] t;
            r = $urandom_range(0, 63) == 0;
            s = $urandom_range(0, 3) == 0;
            d = $urandom_range(0, 7) == 0;
            t = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
            step(r, s, d, t);
        end
        // wrap instance
        @(negedge clk);
        check("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);
        w_rst = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_valid", {31'b0, w_valid}, 32'h1);
        check("wrap_pc", w_if_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", w_if_pc4, 32'h0);
        check("wrap_instr", w_if_instr, 32'hFFFC_1234);
        check("wrap_next_addr", w_addr, 32'h0);
        @(posedge clk);
        #1;
        check("wrap_second_pc", w_if_pc, 32'h0);
        check("wrap_flags", {30'b0, w_halted, w_fault}, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
